wb_gpr_port_arb: RTL and testbench
==================================

Name: wb_gpr_port_arb

Overview:
- Shares the two GPR register-file write ports among NREQ writeback requesters (e.g. EXE, MEM, divider, LSM).
- Produces the registered put_gpr_a/put_gpr_b strobes that decrement the decode scoreboard refcounts.
- Keeps program order for same-register writes: a lower index is always the older instruction and always wins.
- Sits between the pipeline writeback stages and the register file/decode stage.

Parameters:
NREQ, 3, number of writeback requesters (2..4); index 0 is the oldest/deepest stage.
STARVE_LIMIT, 15, consecutive waiting cycles before a requester is flagged starved (fits in 4 bits).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  requester i has a GPR write pending
req_name  input  5*NREQ  GPR number, slice [5i+4:5i]
req_data  input  32*NREQ  write value, slice [32i+31:32i]
req_ready  output  NREQ  combinational grant; transfer when valid&&ready
port_b_disable  input  1  restricts arbitration to port A only
flush  input  1  drop all in-flight outputs (pairs with reset_scoreboard)
put_gpr_a  output  1  registered port A write strobe
put_gpr_a_name  output  5  port A register
put_gpr_a_data  output  32  port A value
put_gpr_b  output  1  registered port B write strobe
put_gpr_b_name  output  5  port B register
put_gpr_b_data  output  32  port B value
starved  output  NREQ  sticky per-requester starvation flag

Behaviour:
- Reset: put_gpr_a=0, put_gpr_b=0, names=0, data=0, starved=0, wait counters=0. req_ready is 0 while reset is high.
- Grant selection (combinational):
  - Grant A goes to the lowest-index valid requester.
  - Grant B goes to the next-lowest valid requester whose name differs from grant A's name.
  - A requester is never granted if a lower-index valid requester targets the same name. This preserves WAW order.
  - At most 2 grants per cycle.
- port_b_disable=1: only grant A is issued.
- Latency: a request accepted in cycle N appears on put_gpr_a/b in cycle N+1, held for exactly one cycle.
- Output registers are reloaded every cycle; a strobe is 0 when there is no grant.
- Port mapping: the older grant always goes to port A. Port B is never valid while port A is invalid.
- A requester must hold valid, name and data stable until ready. An unaccepted request may not be withdrawn except by flush.
- flush=1:
  - Output strobes are cleared next cycle and req_ready=0 this cycle.
  - Wait counters clear; starved is unchanged.
- Starvation tracking:
  - A requester that is valid but not ready increments its 4-bit wait counter, saturating.
  - The counter clears on acceptance or when valid drops.
  - When the counter reaches STARVE_LIMIT, starved[i] is set and stays set until reset. This is a debug aid only; it does not alter priority.
- Simultaneous events: reset overrides flush, and flush overrides grants.
- Same-name at two lower-index requesters: only the oldest is granted. The younger waits at least one cycle.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, adds three 32-bit wrapping counters, readable as outputs stat_dual, stat_conflict and stat_stall:
  - stat_dual: cycles with two grants.
  - stat_conflict: cycles where a same-name conflict suppressed a grant.
  - stat_stall: cycles with any valid-but-not-ready requester.
- The counters clear on reset only.
- When not defined, these ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package/header (arch_defs.vh): GPR_NAME_W=5, GPR_DATA_W=32, WB_NR_PORTS=2 constants.
- One natural sub-module: wb_gpr_pick. It is a combinational find-first-valid that takes a name-exclusion mask and returns a one-hot grant plus an index. It is instantiated twice, once for port A and once for port B with port A's name excluded.

Test Plan:
- Single requester: req0 valid, name=5, data=0xDEADBEEF → ready0=1; next cycle put_gpr_a=1, name 5, data 0xDEADBEEF; put_gpr_b=0.
- Dual grant: req0 name=3 and req2 name=7 valid → both ready; next cycle A carries r3, B carries r7.
- Same-name conflict: req0 and req1 both name=9 → only req0 ready; cycle+1 A=r9 (req0 data); cycle+2 A=r9 (req1 data).
- Three valid, all names distinct, port_b_disable=1 → one grant per cycle in order 0,1,2 over 3 cycles; B never strobes.
- Starvation: req0 and req1 valid continuously, req2 valid → starved[2] sets after 15 waiting cycles and stays set after req2 is accepted.
- Flush mid-stream: accept in cycle N, flush in cycle N+1 → put strobes 0 in cycle N+2, ready=0 during the flush cycle.

Source files
------------

// File: rtl/wb_gpr_port_arb_pkg.sv
// Shared constants and helpers for the GPR writeback port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_gpr_port_arb_pkg;

  localparam int GPR_NAME_W  = 5;
  localparam int GPR_DATA_W  = 32;
  localparam int WB_NR_PORTS = 2;
  localparam int WAIT_CNT_W  = 4;

  // Saturating increment for the per-requester wait counters.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] c);
    return (c == {WAIT_CNT_W{1'b1}}) ? c : c + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/wb_gpr_pick.sv
// Find-first eligible requester, optionally skipping one excluded register name.
// Latency: purely combinational.
// Backpressure: none; the caller gates the resulting grant.
module wb_gpr_pick
  import wb_gpr_port_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]            cand,
  input  logic [NREQ*GPR_NAME_W-1:0] names,
  input  logic                       excl_en,
  input  logic [GPR_NAME_W-1:0]      excl_name,
  output logic [NREQ-1:0]            gnt,
  output logic [IDX_W-1:0]           idx,
  output logic                       found
);

  // Lowest index wins: index order is program order (0 is the oldest).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && cand[i] &&
          !(excl_en && (names[i*GPR_NAME_W +: GPR_NAME_W] == excl_name))) begin
        gnt[i] = 1'b1;
        idx    = i[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_gpr_port_arb.sv
// Shares the two GPR write ports among NREQ writeback requesters, keeping WAW order.
// Latency: accepted in cycle N -> put_gpr_a/b strobe in cycle N+1 for one cycle.
// Backpressure: combinational req_ready; requester holds until ready. Optional stats: WB_ARB_STATS_EN.
module wb_gpr_port_arb
  import wb_gpr_port_arb_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*GPR_NAME_W-1:0] req_name,
  input  logic [NREQ*GPR_DATA_W-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       port_b_disable,
  input  logic                       flush,
  output logic                       put_gpr_a,
  output logic [GPR_NAME_W-1:0]      put_gpr_a_name,
  output logic [GPR_DATA_W-1:0]      put_gpr_a_data,
  output logic                       put_gpr_b,
  output logic [GPR_NAME_W-1:0]      put_gpr_b_name,
  output logic [GPR_DATA_W-1:0]      put_gpr_b_data,
`ifdef WB_ARB_STATS_EN
  output logic [31:0]                stat_dual,
  output logic [31:0]                stat_conflict,
  output logic [31:0]                stat_stall,
`endif
  output logic [NREQ-1:0]            starved
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WAIT_CNT_W-1:0] STARVE_LIM = WAIT_CNT_W'(STARVE_LIMIT);

  logic [NREQ-1:0]       waw_blk;
  logic [NREQ-1:0]       gnt_a, gnt_b;
  logic [IDX_W-1:0]      idx_a, idx_b;
  logic                  found_a, found_b;
  logic                  arb_en, b_en, grant_a, grant_b;
  logic [GPR_NAME_W-1:0] name_a, name_b;
  logic [GPR_DATA_W-1:0] data_a, data_b;
  logic [WAIT_CNT_W-1:0] wait_cnt [NREQ];

  // A requester is blocked while an older valid requester targets the same register.
  always_comb begin
    waw_blk = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (j < i && req_valid[j] &&
            (req_name[j*GPR_NAME_W +: GPR_NAME_W] == req_name[i*GPR_NAME_W +: GPR_NAME_W]))
          waw_blk[i] = 1'b1;
      end
    end
  end

  wb_gpr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_a (
    .cand      (req_valid),
    .names     (req_name),
    .excl_en   (1'b0),
    .excl_name ({GPR_NAME_W{1'b0}}),
    .gnt       (gnt_a),
    .idx       (idx_a),
    .found     (found_a)
  );

  // Port B: younger than A, not WAW-blocked, and not writing A's register.
  wb_gpr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_b (
    .cand      (req_valid & ~gnt_a & ~waw_blk),
    .names     (req_name),
    .excl_en   (found_a),
    .excl_name (name_a),
    .gnt       (gnt_b),
    .idx       (idx_b),
    .found     (found_b)
  );

  assign arb_en    = !reset && !flush;
  assign b_en      = arb_en && !port_b_disable;
  assign grant_a   = found_a && arb_en;
  assign grant_b   = found_b && b_en;
  assign req_ready = (gnt_a & {NREQ{arb_en}}) | (gnt_b & {NREQ{b_en}});

  // One-hot muxes selecting the granted name/data for each port.
  always_comb begin
    name_a = '0;
    data_a = '0;
    name_b = '0;
    data_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_a[i]) begin
        name_a = req_name[i*GPR_NAME_W +: GPR_NAME_W];
        data_a = req_data[i*GPR_DATA_W +: GPR_DATA_W];
      end
      if (gnt_b[i]) begin
        name_b = req_name[i*GPR_NAME_W +: GPR_NAME_W];
        data_b = req_data[i*GPR_DATA_W +: GPR_DATA_W];
      end
    end
  end

  // Output registers reload every cycle; fields are zeroed when the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      put_gpr_a      <= 1'b0;
      put_gpr_a_name <= '0;
      put_gpr_a_data <= '0;
      put_gpr_b      <= 1'b0;
      put_gpr_b_name <= '0;
      put_gpr_b_data <= '0;
    end else begin
      put_gpr_a      <= grant_a;
      put_gpr_a_name <= grant_a ? name_a : '0;
      put_gpr_a_data <= grant_a ? data_a : '0;
      put_gpr_b      <= grant_b;
      put_gpr_b_name <= grant_b ? name_b : '0;
      put_gpr_b_data <= grant_b ? data_b : '0;
    end
  end

  // Wait counters and sticky starvation flags; flush clears counters but not flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      starved <= '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (flush) begin
          wait_cnt[i] <= '0;
        end else if (req_valid[i] && !req_ready[i]) begin
          wait_cnt[i] <= sat_inc(wait_cnt[i]);
          if (sat_inc(wait_cnt[i]) == STARVE_LIM) starved[i] <= 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  // Free-running wrapping event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_dual     <= '0;
      stat_conflict <= '0;
      stat_stall    <= '0;
    end else begin
      if (grant_b)                          stat_dual     <= stat_dual + 32'd1;
      if (arb_en && |(req_valid & waw_blk)) stat_conflict <= stat_conflict + 32'd1;
      if (|(req_valid & ~req_ready))        stat_stall    <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_gpr_port_arb.sv
// Directed self-checking bench for wb_gpr_port_arb (NREQ=3, STARVE_LIMIT=15).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Summary line reports passed/total comparisons.
module tb_wb_gpr_port_arb;

  localparam int NREQ = 3;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*5-1:0]   req_name;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                port_b_disable;
  logic                flush;
  logic                put_gpr_a;
  logic [4:0]          put_gpr_a_name;
  logic [31:0]         put_gpr_a_data;
  logic                put_gpr_b;
  logic [4:0]          put_gpr_b_name;
  logic [31:0]         put_gpr_b_data;
  logic [NREQ-1:0]     starved;
`ifdef WB_ARB_STATS_EN
  logic [31:0]         stat_dual, stat_conflict, stat_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  wb_gpr_port_arb #(.NREQ(NREQ), .STARVE_LIMIT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_name       (req_name),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .port_b_disable (port_b_disable),
    .flush          (flush),
    .put_gpr_a      (put_gpr_a),
    .put_gpr_a_name (put_gpr_a_name),
    .put_gpr_a_data (put_gpr_a_data),
    .put_gpr_b      (put_gpr_b),
    .put_gpr_b_name (put_gpr_b_name),
    .put_gpr_b_data (put_gpr_b_data),
`ifdef WB_ARB_STATS_EN
    .stat_dual      (stat_dual),
    .stat_conflict  (stat_conflict),
    .stat_stall     (stat_stall),
`endif
    .starved        (starved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] n, input logic [31:0] d);
    req_valid[i]      = v;
    req_name[i*5 +: 5] = n;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    req_valid = '0;
    req_name = '0;
    req_data = '0;
    port_b_disable = 1'b0;
    flush = 1'b0;

    // Reset: a valid request must not be readied, outputs are zero.
    set_req(0, 1'b1, 5'd5, 32'h12345678);
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_put_a", 32'(put_gpr_a), 32'h0);
    chk("rst_a_name", 32'(put_gpr_a_name), 32'h0);
    chk("rst_a_data", put_gpr_a_data, 32'h0);
    chk("rst_put_b", 32'(put_gpr_b), 32'h0);
    chk("rst_starved", 32'(starved), 32'h0);
    set_req(0, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    tick();

    // Single requester.
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    chk("single_put_a", 32'(put_gpr_a), 32'h1);
    chk("single_a_name", 32'(put_gpr_a_name), 32'd5);
    chk("single_a_data", put_gpr_a_data, 32'hDEADBEEF);
    chk("single_put_b", 32'(put_gpr_b), 32'h0);
    tick();
    chk("single_one_cycle", 32'(put_gpr_a), 32'h0);

    // Dual grant.
    set_req(0, 1'b1, 5'd3, 32'h11111111);
    set_req(2, 1'b1, 5'd7, 32'h22222222);
    #1 chk("dual_ready", 32'(req_ready), 32'b101);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    chk("dual_put_a", 32'(put_gpr_a), 32'h1);
    chk("dual_a_name", 32'(put_gpr_a_name), 32'd3);
    chk("dual_a_data", put_gpr_a_data, 32'h11111111);
    chk("dual_put_b", 32'(put_gpr_b), 32'h1);
    chk("dual_b_name", 32'(put_gpr_b_name), 32'd7);
    chk("dual_b_data", put_gpr_b_data, 32'h22222222);
    tick();
    chk("dual_b_drop", 32'(put_gpr_b), 32'h0);

    // Same-name conflict between req0 and req1.
    set_req(0, 1'b1, 5'd9, 32'hAAAA0000);
    set_req(1, 1'b1, 5'd9, 32'hBBBB1111);
    #1 chk("waw_ready0", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    chk("waw_a_data0", put_gpr_a_data, 32'hAAAA0000);
    chk("waw_a_name0", 32'(put_gpr_a_name), 32'd9);
    chk("waw_put_b0", 32'(put_gpr_b), 32'h0);
    #1 chk("waw_ready1", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    chk("waw_a_data1", put_gpr_a_data, 32'hBBBB1111);
    chk("waw_put_b1", 32'(put_gpr_b), 32'h0);
    tick();

    // Conflict between req0/req1 while req2 is free: B skips the blocked req1.
    set_req(0, 1'b1, 5'd9, 32'hC0C00000);
    set_req(1, 1'b1, 5'd9, 32'hC1C11111);
    set_req(2, 1'b1, 5'd5, 32'hC2C22222);
    #1 chk("skip_ready", 32'(req_ready), 32'b101);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    chk("skip_a_data", put_gpr_a_data, 32'hC0C00000);
    chk("skip_b_name", 32'(put_gpr_b_name), 32'd5);
    chk("skip_b_data", put_gpr_b_data, 32'hC2C22222);
    #1 chk("skip_ready2", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    chk("skip_a_data2", put_gpr_a_data, 32'hC1C11111);
    tick();

    // Port B disabled: strictly one grant per cycle in index order.
    port_b_disable = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'hD0000000);
    set_req(1, 1'b1, 5'd2, 32'hD0000001);
    set_req(2, 1'b1, 5'd3, 32'hD0000002);
    for (int k = 0; k < 3; k++) begin
      #1 chk("pbd_ready", 32'(req_ready), 32'(1 << k));
      tick();
      set_req(k, 1'b0, 5'd0, 32'h0);
      chk("pbd_a_data", put_gpr_a_data, 32'hD0000000 + 32'(k));
      chk("pbd_put_b", 32'(put_gpr_b), 32'h0);
    end
    port_b_disable = 1'b0;
    tick();

    // Starvation: req0/req1 win every cycle, req2 waits 15 cycles.
    set_req(0, 1'b1, 5'd1, 32'hE0000000);
    set_req(1, 1'b1, 5'd2, 32'hE0000001);
    set_req(2, 1'b1, 5'd3, 32'hE0000002);
    #1 chk("starve_ready", 32'(req_ready), 32'b011);
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 14) chk("starve_before", 32'(starved), 32'b000);
      if (c == 15) chk("starve_set", 32'(starved), 32'b100);
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1 chk("starve_ready2", 32'(req_ready), 32'b100);
    tick();
    set_req(2, 1'b0, 5'd0, 32'h0);
    chk("starve_a_data", put_gpr_a_data, 32'hE0000002);
    tick();
    chk("starve_sticky", 32'(starved), 32'b100);

    // Flush one cycle after an acceptance.
    set_req(0, 1'b1, 5'd4, 32'hF00D0001);
    #1 chk("flush_ready0", 32'(req_ready), 32'b001);
    tick();
    chk("flush_put_n1", 32'(put_gpr_a), 32'h1);
    set_req(0, 1'b1, 5'd6, 32'hF00D0002);
    flush = 1'b1;
    #1 chk("flush_ready_blk", 32'(req_ready), 32'b000);
    tick();
    flush = 1'b0;
    chk("flush_put_a", 32'(put_gpr_a), 32'h0);
    chk("flush_put_b", 32'(put_gpr_b), 32'h0);
    chk("flush_starved", 32'(starved), 32'b100);
    #1 chk("flush_ready_after", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    chk("flush_a_data", put_gpr_a_data, 32'hF00D0002);
    chk("flush_a_name", 32'(put_gpr_a_name), 32'd6);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
